fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the core. It replaces the fixed single-cycle PC register, PC+4 adder and combinational ROM lookup.
- It owns the fetch PC and issues reads to a synchronous-read instruction ROM with one-cycle latency.
- Returned words are buffered with their PC in a DEPTH-entry queue, which drives the decode stage through a valid/ready handshake.
- The execute stage redirects fetch (branch/jump) through a flush port.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one-cycle-latency ROM
// reads and buffers returned words with their PC in a circular queue for decode.
module fetch_queue #(
   parameter int               XLEN     = 32,
   parameter int               ILEN     = 32,
   parameter int               ADDR_W   = 8,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         rom_en,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [ILEN-1:0]              rom_inst,
   input  logic                         redirect,
   input  logic [XLEN-1:0]              redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ILEN-1:0]              out_inst,
   output logic [XLEN-1:0]              out_pc,
   output logic [XLEN-1:0]              out_pc_plus4,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
   logic             inflight_q, inflight_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ILEN-1:0]  mem_inst_q [DEPTH];
   logic [ILEN-1:0]  mem_inst_d [DEPTH];
   logic [XLEN-1:0]  mem_pc_q [DEPTH];
   logic [XLEN-1:0]  mem_pc_d [DEPTH];

   logic             pop;
   logic             push;
   logic             issue;
   logic [CNT_W:0]   occupancy;
   logic             unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign out_valid = ~rst & (count_q != '0);
   assign pop       = out_valid & out_ready & ~redirect;
   assign push      = inflight_q & ~redirect & ~rst;

   // Credit includes the outstanding read so a returning word always has a slot.
   assign occupancy = ({1'b0, count_q} + (CNT_W+1)'(inflight_q)) - (CNT_W+1)'(pop);
   assign issue     = ~rst & ~redirect & (occupancy < DEPTH_C);

   assign rom_en       = issue;
   assign rom_addr     = rst ? RESET_PC[ADDR_W+1:2] : fetch_pc_q[ADDR_W+1:2];
   assign out_inst     = out_valid ? mem_inst_q[rd_ptr_q] : '0;
   assign out_pc       = out_valid ? mem_pc_q[rd_ptr_q] : '0;
   assign out_pc_plus4 = out_valid ? (mem_pc_q[rd_ptr_q] + XLEN'(4)) : '0;
   assign queue_count  = rst ? '0 : count_q;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = inflight_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      mem_inst_d    = mem_inst_q;
      mem_pc_d      = mem_pc_q;

      if (redirect) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            mem_inst_d[wr_ptr_q] = rom_inst;
            mem_pc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
         inflight_d = issue;
         if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= RESET_PC;
         inflight_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Queue storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      mem_inst_q <= mem_inst_d;
      mem_pc_q   <= mem_pc_d;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, wrap and reset.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        rom_en;
   logic [7:0]  rom_addr;
   logic [31:0] rom_inst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [2:0]  queue_count;

   int n_total = 0;
   int n_pass  = 0;

   fetch_queue #(
      .XLEN(32), .ILEN(32), .ADDR_W(8), .DEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst(rst),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
      .queue_count(queue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: word k holds 0x1000_0000 + k.
   initial rom_inst = 32'h0;
   always @(posedge clk) if (rom_en) rom_inst <= 32'h1000_0000 + {24'h0, rom_addr};

   // The queue must never report more than DEPTH entries.
   always @(negedge clk) begin
      if (!rst) begin
         if (queue_count > 3'd4) $display("FAIL overflow queue_count=%0d limit=4", queue_count);
         else n_pass++;
         n_total++;
      end
   end

   task automatic reset_dut();
      @(negedge clk); rst = 1'b1; redirect = 1'b0;
      @(negedge clk); rst = 1'b0; #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      @(negedge clk); @(negedge clk); #1;
      if (rom_en !== 1'b0) $display("FAIL rst_rom_en got=%b want=0", rom_en); else n_pass++;
      n_total++;
      if (rom_addr !== 8'h00) $display("FAIL rst_rom_addr got=%h want=00", rom_addr); else n_pass++;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
      n_total++;
      if (queue_count !== 3'd0) $display("FAIL rst_count got=%0d want=0", queue_count); else n_pass++;
      n_total++;
      if (out_pc !== 32'h0) $display("FAIL rst_out_pc got=%h want=0", out_pc); else n_pass++;
      n_total++;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      reset_dut();
      if (rom_en !== 1'b1 || rom_addr !== 8'h00)
         $display("FAIL stream_first_issue got en=%b addr=%h want en=1 addr=00", rom_en, rom_addr);
      else n_pass++;
      n_total++;
      for (int k = 1; k < 10; k++) begin
         @(negedge clk); #1;
         if (rom_en !== 1'b1 || rom_addr !== 8'(k))
            $display("FAIL stream_issue c%0d got en=%b addr=%h want en=1 addr=%h", k, rom_en, rom_addr, 8'(k));
         else n_pass++;
         n_total++;
         if (k == 1) begin
            if (out_valid !== 1'b0) $display("FAIL stream_latency got=%b want=0", out_valid); else n_pass++;
            n_total++;
         end else begin
            if (out_valid !== 1'b1 || out_pc !== 32'(4*(k-2)) || out_inst !== 32'h1000_0000 + 32'(k-2)
                || out_pc_plus4 !== 32'(4*(k-1)))
               $display("FAIL stream_head c%0d got v=%b pc=%h inst=%h p4=%h want v=1 pc=%h inst=%h p4=%h",
                        k, out_valid, out_pc, out_inst, out_pc_plus4,
                        32'(4*(k-2)), 32'h1000_0000 + 32'(k-2), 32'(4*(k-1)));
            else n_pass++;
            n_total++;
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      reset_dut();
      for (int k = 1; k < 10; k++) begin
         @(negedge clk); #1;
         if (k >= 5) begin
            if (rom_en !== 1'b0 || queue_count !== 3'd4)
               $display("FAIL bp_full c%0d got en=%b cnt=%0d want en=0 cnt=4", k, rom_en, queue_count);
            else n_pass++;
            n_total++;
         end
      end
      if (out_valid !== 1'b1 || out_pc !== 32'h0)
         $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
      else n_pass++;
      n_total++;
      for (int k = 10; k < 20; k++) begin
         @(negedge clk); out_ready = 1'b1; #1;
         if (k == 10) begin
            if (rom_en !== 1'b1 || rom_addr !== 8'h04)
               $display("FAIL bp_resume got en=%b addr=%h want en=1 addr=04", rom_en, rom_addr);
            else n_pass++;
            n_total++;
         end
         if (out_valid !== 1'b1 || out_pc !== 32'(4*(k-10)) || out_inst !== 32'h1000_0000 + 32'(k-10))
            $display("FAIL bp_drain c%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                     k, out_valid, out_pc, out_inst, 32'(4*(k-10)), 32'h1000_0000 + 32'(k-10));
         else n_pass++;
         n_total++;
      end
   endtask

   task automatic test_redirect_flush();
      out_ready = 1'b0;
      reset_dut();
      repeat (3) @(negedge clk);
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h40; #1;
      if (queue_count !== 3'd3 || rom_en !== 1'b0)
         $display("FAIL flush_redirect_cycle got cnt=%0d en=%b want cnt=3 en=0", queue_count, rom_en);
      else n_pass++;
      n_total++;
      @(negedge clk); redirect = 1'b0; out_ready = 1'b1; #1;
      if (queue_count !== 3'd0 || out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 8'h10)
         $display("FAIL flush_next got cnt=%0d v=%b en=%b addr=%h want cnt=0 v=0 en=1 addr=10",
                  queue_count, out_valid, rom_en, rom_addr);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (queue_count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL flush_stale got cnt=%0d v=%b want cnt=0 v=0", queue_count, out_valid);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h1000_0010)
         $display("FAIL flush_target got v=%b pc=%h inst=%h want v=1 pc=40 inst=10000010",
                  out_valid, out_pc, out_inst);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_pc !== 32'h44) $display("FAIL flush_second got pc=%h want 44", out_pc); else n_pass++;
      n_total++;
   endtask

   task automatic test_redirect_pop();
      out_ready = 1'b1;
      reset_dut();
      repeat (3) @(negedge clk);
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h80; #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h8)
         $display("FAIL rpop_head got v=%b pc=%h want v=1 pc=8", out_valid, out_pc);
      else n_pass++;
      n_total++;
      @(negedge clk); redirect = 1'b0; #1;
      if (out_valid !== 1'b0 || queue_count !== 3'd0)
         $display("FAIL rpop_flush got v=%b cnt=%0d want v=0 cnt=0", out_valid, queue_count);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b0) $display("FAIL rpop_gap got v=%b want 0", out_valid); else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h80 || queue_count !== 3'd1)
         $display("FAIL rpop_target got v=%b pc=%h cnt=%0d want v=1 pc=80 cnt=1", out_valid, out_pc, queue_count);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_pc !== 32'h84) $display("FAIL rpop_next got pc=%h want 84", out_pc); else n_pass++;
      n_total++;
   endtask

   task automatic test_align_wrap();
      out_ready = 1'b1;
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h43;
      @(negedge clk); redirect = 1'b0; #1;
      if (rom_addr !== 8'h10) $display("FAIL align_addr got=%h want=10", rom_addr); else n_pass++;
      n_total++;
      repeat (2) @(negedge clk);
      #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h40)
         $display("FAIL align_pc got v=%b pc=%h want v=1 pc=40", out_valid, out_pc);
      else n_pass++;
      n_total++;
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk); redirect = 1'b0; #1;
      if (rom_en !== 1'b1 || rom_addr !== 8'hFF)
         $display("FAIL wrap_addr0 got en=%b addr=%h want en=1 addr=ff", rom_en, rom_addr);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (rom_addr !== 8'h00) $display("FAIL wrap_addr1 got=%h want=00", rom_addr); else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0 || out_inst !== 32'h1000_00FF)
         $display("FAIL wrap_first got pc=%h p4=%h inst=%h want pc=fffffffc p4=0 inst=100000ff",
                  out_pc, out_pc_plus4, out_inst);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_pc !== 32'h0 || out_pc_plus4 !== 32'h4 || out_inst !== 32'h1000_0000)
         $display("FAIL wrap_second got pc=%h p4=%h inst=%h want pc=0 p4=4 inst=10000000",
                  out_pc, out_pc_plus4, out_inst);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk); redirect_pc = 32'h200; #1;
      if (rom_en !== 1'b0) $display("FAIL b2b_en got=%b want=0", rom_en); else n_pass++;
      n_total++;
      @(negedge clk); redirect = 1'b0; #1;
      if (rom_addr !== 8'h80 || queue_count !== 3'd0)
         $display("FAIL b2b_addr got addr=%h cnt=%0d want addr=80 cnt=0", rom_addr, queue_count);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b0) $display("FAIL b2b_gap got v=%b want 0", out_valid); else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h200)
         $display("FAIL b2b_target got v=%b pc=%h want v=1 pc=200", out_valid, out_pc);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      reset_dut();
      repeat (9) @(negedge clk);
      #1;
      if (queue_count !== 3'd4) $display("FAIL mrst_full got=%0d want=4", queue_count); else n_pass++;
      n_total++;
      @(negedge clk); out_ready = 1'b1; #1;
      if (rom_en !== 1'b1) $display("FAIL mrst_issue got=%b want=1", rom_en); else n_pass++;
      n_total++;
      @(negedge clk); out_ready = 1'b0; rst = 1'b1; #1;
      if (out_valid !== 1'b0 || queue_count !== 3'd0 || rom_en !== 1'b0 || rom_addr !== 8'h00)
         $display("FAIL mrst_during got v=%b cnt=%0d en=%b addr=%h want v=0 cnt=0 en=0 addr=00",
                  out_valid, queue_count, rom_en, rom_addr);
      else n_pass++;
      n_total++;
      @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
      if (out_valid !== 1'b0 || queue_count !== 3'd0 || rom_en !== 1'b1 || rom_addr !== 8'h00)
         $display("FAIL mrst_after got v=%b cnt=%0d en=%b addr=%h want v=0 cnt=0 en=1 addr=00",
                  out_valid, queue_count, rom_en, rom_addr);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b0 || queue_count !== 3'd0)
         $display("FAIL mrst_stale got v=%b cnt=%0d want v=0 cnt=0", out_valid, queue_count);
      else n_pass++;
      n_total++;
      @(negedge clk); #1;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000_0000)
         $display("FAIL mrst_restart got v=%b pc=%h inst=%h want v=1 pc=0 inst=10000000",
                  out_valid, out_pc, out_inst);
      else n_pass++;
      n_total++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_redirect_pop();
      test_align_wrap();
      test_back_to_back();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
